// File: rtl/mul_iter_if.sv
// Handshake bundle for the iterative multiplier: operand offer, flush, result return and busy.
interface mul_iter_if #(
    parameter int unsigned WIDTH = 32
) ();
    logic               in_valid;
    logic               in_ready;
    logic               mul_sign;
    logic [WIDTH-1:0]   op1;
    logic [WIDTH-1:0]   op2;
    logic               flush;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] result;
    logic               busy;

    modport master (
        output in_valid, mul_sign, op1, op2, flush, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  in_valid, mul_sign, op1, op2, flush, out_ready,
        output in_ready, out_valid, result, busy
    );
endinterface

// File: rtl/mul_iter.sv
// Fixed-latency iterative shift-add multiplier, signed or unsigned per operation.
// Define MUL_ITER_RADIX4_EN to retire two multiplier bits per cycle instead of one.
module mul_iter #(
    parameter int unsigned WIDTH = 32
) (
    input logic       clk,
    input logic       reset,
    mul_iter_if.slave bus_io
);

`ifdef MUL_ITER_RADIX4_EN
    localparam int unsigned Steps = WIDTH / 2;
`else
    localparam int unsigned Steps = WIDTH;
`endif
    localparam int unsigned CntW = $clog2(Steps + 1);
    localparam int unsigned PW   = 2 * WIDTH;

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  mcand_q, mcand_d;
    logic [PW-1:0]     acc_q, acc_d, acc_step;
    logic [PW-1:0]     result_q, result_d;
    logic              neg_q, neg_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]  mag1, mag2;

    // Most negative input maps onto itself, which is the correct unsigned magnitude.
    assign mag1 = (bus_io.mul_sign && bus_io.op1[WIDTH-1]) ? (~bus_io.op1 + WIDTH'(1))
                                                           : bus_io.op1;
    assign mag2 = (bus_io.mul_sign && bus_io.op2[WIDTH-1]) ? (~bus_io.op2 + WIDTH'(1))
                                                           : bus_io.op2;

    // Accumulator holds {partial sum, remaining multiplier bits}; each step shifts right.
`ifdef MUL_ITER_RADIX4_EN
    logic [WIDTH+1:0] addend4, sum4;

    always_comb begin
        addend4 = '0;
        unique case (acc_q[1:0])
            2'd0: addend4 = '0;
            2'd1: addend4 = {2'b00, mcand_q};
            2'd2: addend4 = {1'b0, mcand_q, 1'b0};
            2'd3: addend4 = {2'b00, mcand_q} + {1'b0, mcand_q, 1'b0};
            default: addend4 = '0;
        endcase
        sum4     = {2'b00, acc_q[PW-1:WIDTH]} + addend4;
        acc_step = {sum4, acc_q[WIDTH-1:2]};
    end
`else
    logic [WIDTH:0] sum2;

    always_comb begin
        sum2     = {1'b0, acc_q[PW-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
        acc_step = {sum2, acc_q[WIDTH-1:1]};
    end
`endif

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        neg_d    = neg_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        if (bus_io.flush) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus_io.in_valid) begin
                        state_d = StCalc;
                        mcand_d = mag1;
                        acc_d   = {{WIDTH{1'b0}}, mag2};
                        neg_d   = bus_io.mul_sign & (bus_io.op1[WIDTH-1] ^ bus_io.op2[WIDTH-1]);
                        cnt_d   = '0;
                    end
                end
                StCalc: begin
                    // One extra cycle after the last step folds in the sign.
                    if (cnt_q == CntW'(Steps)) begin
                        result_d = neg_q ? (~acc_q + PW'(1)) : acc_q;
                        state_d  = StDone;
                    end else begin
                        acc_d = acc_step;
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                StDone: begin
                    if (bus_io.out_ready) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            mcand_q  <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            neg_q    <= neg_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign bus_io.in_ready  = (state_q == StIdle) && !bus_io.flush;
    assign bus_io.out_valid = (state_q == StDone);
    assign bus_io.busy      = (state_q != StIdle);
    assign bus_io.result    = result_q;

endmodule

// File: tb/tb_mul_iter.sv
// Scoreboard bench for mul_iter: directed products, latency, hold, flush and reset recovery.
module tb_mul_iter;

`ifdef MUL_ITER_RADIX4_EN
    localparam int N = 16;
`else
    localparam int N = 32;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    logic ov_prev = 1'b0;

    logic [63:0] exp_q[$];
    int          acc_cyc_q[$];

    mul_iter_if #(.WIDTH(32)) bus ();

    mul_iter #(.WIDTH(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .bus_io (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Monitor: latency on each out_valid rise, result on each pop.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.out_valid && !ov_prev) begin
                if (acc_cyc_q.size() == 0) chk("unexpected_out_valid", 1, 0);
                else chk("latency", cyc - acc_cyc_q.pop_front(), N + 1);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) chk("unexpected_pop", 1, 0);
                else chk("result", bus.result, exp_q.pop_front());
            end
            if (bus.in_valid && bus.in_ready) acc_cyc_q.push_back(cyc + 1);
        end
        ov_prev = bus.out_valid;
    end

    task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp);
        int n = 0;
        while (!bus.in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.in_ready) chk("issue_timeout", 1, 0);
        bus.in_valid = 1'b1;
        bus.mul_sign = s;
        bus.op1      = a;
        bus.op2      = b;
        exp_q.push_back(exp);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || bus.out_valid) && n < 3 * N + 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (exp_q.size() != 0 || bus.out_valid) begin
            chk("drain_timeout", 1, 0);
            exp_q.delete();
            acc_cyc_q.delete();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.mul_sign  = 1'b0;
        bus.op1       = '0;
        bus.op2       = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_result", bus.result, 0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_in_ready", bus.in_ready, 1);

        issue(0, 32'd7, 32'd6, 64'h0000_0000_0000_002A);
        drain();
        issue(1, 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1);
        drain();
        issue(0, 32'hFFFF_FFFD, 32'd5, 64'h0000_0004_FFFF_FFF1);
        drain();
        issue(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
        drain();
        issue(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001);
        drain();
        issue(1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
        drain();
        issue(1, 32'h8000_0000, 32'd1, 64'hFFFF_FFFF_8000_0000);
        drain();
        issue(0, 32'd0, 32'h1234_5678, 64'h0);
        drain();

        // Back-pressure: result held in DONE, new offers ignored.
        bus.out_ready = 1'b0;
        issue(0, 32'h10, 32'h3, 64'h30);
        for (int n = 0; n < 3 * N && !bus.out_valid; n++) begin
            @(posedge clk); #1;
        end
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'b1;
            bus.op1      = 32'd100 + i;
            bus.op2      = 32'd9;
            @(negedge clk);
            chk("hold_out_valid", bus.out_valid, 1);
            chk("hold_result", bus.result, 64'h30);
            chk("hold_in_ready", bus.in_ready, 0);
            @(posedge clk); #1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("pop_out_valid", bus.out_valid, 0);
        chk("pop_in_ready", bus.in_ready, 1);
        chk("pop_consumed", exp_q.size(), 0);

        // Flush in CALC cycle 5.
        issue(0, 32'd9, 32'd9, 64'd81);
        repeat (4) begin
            @(posedge clk); #1;
        end
        bus.flush = 1'b1;
        @(negedge clk);
        chk("flush_in_ready", bus.in_ready, 0);
        @(posedge clk); #1;
        bus.flush = 1'b0;
        exp_q.delete();
        acc_cyc_q.delete();
        chk("flush_out_valid", bus.out_valid, 0);
        chk("flush_busy", bus.busy, 0);
        chk("flush_keep_result", bus.result, 64'h30);
        repeat (N + 5) begin
            @(posedge clk); #1;
        end
        chk("flush_no_out", bus.out_valid, 0);
        issue(0, 32'd2, 32'd3, 64'd6);
        drain();

        // Reset mid-CALC.
        issue(0, 32'd5, 32'd5, 64'd25);
        repeat (10) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        exp_q.delete();
        acc_cyc_q.delete();
        chk("midrst_in_ready", bus.in_ready, 1);
        chk("midrst_out_valid", bus.out_valid, 0);
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_result", bus.result, 0);
        reset = 1'b0;
        repeat (N + 5) begin
            @(posedge clk); #1;
        end
        chk("midrst_no_out", bus.out_valid, 0);
        issue(0, 32'd7, 32'd6, 64'h2A);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
